snake_body_engine: RTL
======================

# snake_body_engine

Game-state writer for the snake game: owns the snake body position array, length and direction, and advances them one grid cell per game tick. It sits between the debounced button pulses and the display/SSD logic, producing the flat location bus, length and status flags those blocks read. Each tick runs a serial self-collision scan, so the block is a small multi-cycle state machine clocked on board_clk with tick enables rather than a divided clock.

## Interface
Parameters:
- COORD_W, 4: bits per coordinate; grid is 2^COORD_W x 2^COORD_W.
- MAX_LEN, 16: maximum segments; must be ≤ 2^COORD_W.
- INIT_LEN, 3: length after start/reset; must satisfy 2 ≤ INIT_LEN ≤ MAX_LEN.

Ports:
- board_clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clock board_clk.
- start  in  1  one-cycle pulse; (re)initialises the snake and arms play.
- step  in  1  one-cycle game-tick pulse.
- dir_valid  in  1  one-cycle pulse qualifying dir_req.
- dir_req  in  2  requested direction: 00 up, 01 down, 10 left, 11 right.
- food_loc  in  2*COORD_W  food cell {x,y}.
- locations_flat  out  MAX_LEN*2*COORD_W  segment i at bits [(i+1)*2*COORD_W-1 : i*2*COORD_W]; segment 0 is the head; each segment {x,y}.
- length  out  $clog2(MAX_LEN+1)  live segment count.
- ate  out  1  one-cycle pulse on the commit that consumed food.
- dead  out  1  level; set on collision.
- won  out  1  level; set when length reaches MAX_LEN.
- busy  out  1  high in SCAN and COMMIT.
- overrun  out  1  sticky; step arrived while busy.

## Operation
- States: IDLE, ARMED, SCAN, COMMIT, DEAD, WON.
- Init (on reset or start): segment i = {x = INIT_LEN-1-i, y = 0} for i < INIT_LEN, other segments 0; length = INIT_LEN; dir = right; ate = dead = won = overrun = 0.
- Reset → IDLE with init values. start in IDLE/DEAD/WON → init, → ARMED. start in ARMED/SCAN/COMMIT → init, → ARMED; any scan in progress is aborted.
- Direction: dir_valid latches dir_req into pending_dir unless it is the exact reverse of the committed dir (ignored). Committed dir = pending_dir, taken when step is accepted.
- ARMED + step: compute next head = head ± 1 on x or y; eat = (next head == food_loc); scan limit N = length-1 (tail vacates), or length if eat; idx = 0; → SCAN.
- SCAN: one comparison per cycle, next head vs segment idx; match sets hit. Leaves after idx = N-1.
- COMMIT: if hit or wall fault → DEAD, array unchanged. Else shift segments i→i+1, write head; if eat: length+1, pulse ate; if new length = MAX_LEN → WON, else → ARMED.
- Width rule: coordinate arithmetic is COORD_W bits unsigned; see Configuration for edge behaviour.
- step in IDLE/DEAD/WON ignored. step while busy ignored and sets overrun (cleared only by init).
- dir_valid and step in the same cycle: the new request is applied before the step is taken.

## Timing
- Array, length, ate, dead, won update on the COMMIT edge: N+2 cycles after the edge sampling step.
- busy rises the edge after step, falls with COMMIT exit.
- ate high exactly one cycle, coincident with the updated array.
- All outputs registered; reset values are the init values above, state IDLE, busy = 0.

## Configuration
- SNAKE_WRAP_EN defined: head leaving an edge wraps modulo 2^COORD_W; wall fault never raised.
- Undefined: a move past x/y = 0 or 2^COORD_W-1 sets wall fault; COMMIT goes to DEAD, array unchanged.

## Test plan
- Reset, start, one step, food_loc far: after 4 cycles (N=2) head = (3,0), segments (2,0),(1,0), length 3, ate 0.
- food_loc = (3,0), start, step: at N=3 cycles+2 length = 4, ate one-cycle pulse, tail (0,0) retained.
- Start, dir_valid with left (reverse): ignored; step moves head to (3,0). Then down, step → head (3,1).
- Without SNAKE_WRAP_EN: start, up, step → dead = 1, array unchanged; with it → head (2,2^COORD_W-1), alive.
- Self-collision: grow to 5, steer down, left, up → dead on third commit; step while busy → overrun = 1.
- Mid-SCAN start pulse: next cycle state ARMED, init array, busy 0, overrun 0.

Source files
------------

// File: rtl/snake_body_engine.sv
// Snake body/length/direction state machine; each game tick runs a serial self-collision scan.
// Build option: define SNAKE_WRAP_EN to wrap the head around grid edges instead of dying at the wall.
module snake_body_engine #(
  parameter int COORD_W  = 4,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3
) (
  input  logic                           board_clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           step,
  input  logic                           dir_valid,
  input  logic [1:0]                     dir_req,
  input  logic [2*COORD_W-1:0]           food_loc,
  output logic [MAX_LEN*2*COORD_W-1:0]   locations_flat,
  output logic [$clog2(MAX_LEN+1)-1:0]   length,
  output logic                           ate,
  output logic                           dead,
  output logic                           won,
  output logic                           busy,
  output logic                           overrun
);

  localparam int SEG_W = 2*COORD_W;
  localparam int LEN_W = $clog2(MAX_LEN+1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_SCAN   = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_DEAD   = 3'd4;
  localparam logic [2:0] S_WON    = 3'd5;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [COORD_W-1:0] C_ONE   = 1;
  localparam logic [COORD_W-1:0] C_MAX   = '1;
  localparam logic [LEN_W-1:0]   LEN_ONE = 1;

  function automatic logic [SEG_W-1:0] init_seg(input int i);
    logic [COORD_W-1:0] x;
    x = '0;
    if (i < INIT_LEN) x = COORD_W'(INIT_LEN - 1 - i);
    return {x, {COORD_W{1'b0}}};
  endfunction

  logic [2:0]         state_q, state_d;
  logic [SEG_W-1:0]   seg_q [MAX_LEN];
  logic [SEG_W-1:0]   seg_d [MAX_LEN];
  logic [LEN_W-1:0]   length_q, length_d, idx_q, idx_d, limit_q, limit_d;
  logic [1:0]         dir_q, dir_d, pend_q, pend_d;
  logic [SEG_W-1:0]   next_head_q, next_head_d;
  logic               eat_q, eat_d, wall_q, wall_d, hit_q, hit_d;
  logic               ate_q, ate_d, dead_q, dead_d, won_q, won_d;
  logic               busy_q, busy_d, overrun_q, overrun_d;

  logic [1:0]         move_dir;
  logic [COORD_W-1:0] head_x, head_y, step_x, step_y;
  logic               step_wall, step_eat;
  logic [SEG_W-1:0]   step_head, scan_seg;
  logic [LEN_W-1:0]   length_inc;

  // A same-cycle direction request counts before the step; exact reversals are dropped.
  always_comb begin
    move_dir = pend_q;
    if (dir_valid && ((dir_req ^ dir_q) != 2'b01)) move_dir = dir_req;
    head_x = seg_q[0][SEG_W-1:COORD_W];
    head_y = seg_q[0][COORD_W-1:0];
    step_x = head_x;
    step_y = head_y;
    step_wall = 1'b0;
    case (move_dir)
      DIR_UP:   begin step_y = head_y - C_ONE; step_wall = (head_y == '0);    end
      DIR_DOWN: begin step_y = head_y + C_ONE; step_wall = (head_y == C_MAX); end
      DIR_LEFT: begin step_x = head_x - C_ONE; step_wall = (head_x == '0);    end
      default:  begin step_x = head_x + C_ONE; step_wall = (head_x == C_MAX); end
    endcase
`ifdef SNAKE_WRAP_EN
    step_wall = 1'b0;
`endif
    step_head  = {step_x, step_y};
    step_eat   = (step_head == food_loc);
    length_inc = length_q + LEN_ONE;
  end

  always_comb begin
    scan_seg = '0;
    for (int i = 0; i < MAX_LEN; i++)
      if (idx_q == LEN_W'(i)) scan_seg = seg_q[i];
  end

  // The tail slot is only scanned when eating, since otherwise it vacates on this move.
  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    length_d    = length_q;
    dir_d       = dir_q;
    pend_d      = move_dir;
    next_head_d = next_head_q;
    eat_d       = eat_q;
    wall_d      = wall_q;
    hit_d       = hit_q;
    idx_d       = idx_q;
    limit_d     = limit_q;
    ate_d       = 1'b0;
    dead_d      = dead_q;
    won_d       = won_q;
    overrun_d   = overrun_q;

    case (state_q)
      S_ARMED: begin
        if (step) begin
          dir_d       = move_dir;
          next_head_d = step_head;
          eat_d       = step_eat;
          wall_d      = step_wall;
          hit_d       = 1'b0;
          idx_d       = '0;
          limit_d     = step_eat ? length_q : length_q - LEN_ONE;
          state_d     = S_SCAN;
        end
      end
      S_SCAN: begin
        if (step) overrun_d = 1'b1;
        if (idx_q == limit_q) begin
          state_d = S_COMMIT;
        end else begin
          if (scan_seg == next_head_q) hit_d = 1'b1;
          idx_d = idx_q + LEN_ONE;
        end
      end
      S_COMMIT: begin
        if (step) overrun_d = 1'b1;
        if (hit_q || wall_q) begin
          dead_d  = 1'b1;
          state_d = S_DEAD;
        end else begin
          for (int i = MAX_LEN-1; i > 0; i--) seg_d[i] = seg_q[i-1];
          seg_d[0] = next_head_q;
          state_d  = S_ARMED;
          if (eat_q) begin
            length_d = length_inc;
            ate_d    = 1'b1;
            if (length_inc == LEN_W'(MAX_LEN)) begin
              won_d   = 1'b1;
              state_d = S_WON;
            end
          end
        end
      end
      default: ;
    endcase

    if (start) begin
      state_d   = S_ARMED;
      for (int i = 0; i < MAX_LEN; i++) seg_d[i] = init_seg(i);
      length_d  = LEN_W'(INIT_LEN);
      dir_d     = DIR_RIGHT;
      pend_d    = DIR_RIGHT;
      idx_d     = '0;
      hit_d     = 1'b0;
      ate_d     = 1'b0;
      dead_d    = 1'b0;
      won_d     = 1'b0;
      overrun_d = 1'b0;
    end

    busy_d = (state_d == S_SCAN) || (state_d == S_COMMIT);
  end

  always_ff @(posedge board_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= init_seg(i);
      length_q    <= LEN_W'(INIT_LEN);
      dir_q       <= DIR_RIGHT;
      pend_q      <= DIR_RIGHT;
      next_head_q <= '0;
      eat_q       <= 1'b0;
      wall_q      <= 1'b0;
      hit_q       <= 1'b0;
      idx_q       <= '0;
      limit_q     <= '0;
      ate_q       <= 1'b0;
      dead_q      <= 1'b0;
      won_q       <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= seg_d[i];
      length_q    <= length_d;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      next_head_q <= next_head_d;
      eat_q       <= eat_d;
      wall_q      <= wall_d;
      hit_q       <= hit_d;
      idx_q       <= idx_d;
      limit_q     <= limit_d;
      ate_q       <= ate_d;
      dead_q      <= dead_d;
      won_q       <= won_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_flat
    assign locations_flat[g*SEG_W +: SEG_W] = seg_q[g];
  end

  assign length  = length_q;
  assign ate     = ate_q;
  assign dead    = dead_q;
  assign won     = won_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule
